// File: rtl/sqrt_datapath_seq.sv
// Restoring digit-by-digit integer square root engine.
// Regfile + ALU datapath driven by a built-in microsequencer.
module sqrt_datapath_seq #(
   parameter int WIDTH = 32,
   parameter int NUM_REGS = 8,
   localparam int ADDR_W = $clog2(NUM_REGS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH/2-1:0] root_o,
   output logic [WIDTH-1:0]   rem_o,
   output logic               busy_o,
   input  logic [ADDR_W-1:0]  dbg_addr_i,
   output logic [WIDTH-1:0]   dbg_data_o
);

   localparam int IW = (WIDTH/2 > 1) ? $clog2(WIDTH/2) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH/2-1);
   localparam logic [WIDTH-1:0] BIT_INIT = {2'b01, {(WIDTH-2){1'b0}}};

   localparam logic [ADDR_W-1:0] R_X   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] R_RES = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] R_BIT = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] R_TMP = ADDR_W'(3);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT0, S_INIT1, S_ADD, S_CMP,
      S_SHR, S_UPD, S_BIT, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_SHR1, OP_SHR2, OP_ZERO, OP_PASS
   } alu_op_t;

   state_t state, next;
   alu_op_t op;

   logic [WIDTH-1:0] rf [NUM_REGS];
   logic [ADDR_W-1:0] ra, rb, wa;
   logic we, ie, use_const, take, borrow;
   logic [WIDTH-1:0] a, b, alu_y, wdata;
   logic [IW-1:0] iter;

   assign a = rf[ra];
   assign b = use_const ? BIT_INIT : rf[rb];
   assign borrow = a < b;
   assign dbg_data_o = rf[dbg_addr_i];
   assign in_ready = (state == S_IDLE);
   assign busy_o = (state != S_IDLE);

   always_comb begin
      alu_y = b;
      unique case (op)
         OP_ADD:  alu_y = a + b;
         OP_SUB:  alu_y = a - b;
         OP_SHR1: alu_y = a >> 1;
         OP_SHR2: alu_y = a >> 2;
         OP_ZERO: alu_y = '0;
         OP_PASS: alu_y = b;
         default: alu_y = b;
      endcase
   end

   assign wdata = ie ? data_i : alu_y;

   always_comb begin
      next = state;
      we = 1'b0;
      wa = R_X;
      ra = R_X;
      rb = R_X;
      op = OP_PASS;
      use_const = 1'b0;
      ie = 1'b0;
      unique case (state)
         S_IDLE: begin
            ie = 1'b1;
            we = in_valid;
            if (in_valid) next = S_INIT0;
         end
         S_INIT0: begin
            op = OP_ZERO; wa = R_RES; we = 1'b1;
            next = S_INIT1;
         end
         S_INIT1: begin
            op = OP_PASS; use_const = 1'b1;
            wa = R_BIT; we = 1'b1;
            next = S_ADD;
         end
         S_ADD: begin
            ra = R_RES; rb = R_BIT; op = OP_ADD;
            wa = R_TMP; we = 1'b1;
            next = S_CMP;
         end
         S_CMP: begin
            ra = R_X; rb = R_TMP; op = OP_SUB;
            wa = R_X; we = ~borrow;
            next = S_SHR;
         end
         S_SHR: begin
            ra = R_RES; op = OP_SHR1;
            wa = R_RES; we = 1'b1;
            next = S_UPD;
         end
         S_UPD: begin
            ra = R_RES; rb = R_BIT; op = OP_ADD;
            wa = R_RES; we = take;
            next = S_BIT;
         end
         S_BIT: begin
            ra = R_BIT; op = OP_SHR2;
            wa = R_BIT; we = 1'b1;
            next = (iter == LAST) ? S_DONE : S_ADD;
         end
         S_DONE: begin
            if (out_ready) next = S_IDLE;
         end
         default: next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (we) begin
         rf[wa] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         iter <= '0;
         take <= 1'b0;
         root_o <= '0;
         rem_o <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= next;
         if (state == S_IDLE) iter <= '0;
         if (state == S_CMP) take <= ~borrow;
         if (state == S_BIT) begin
            iter <= iter + 1'b1;
            // R0/R1 are already final when the last BIT step runs
            if (iter == LAST) begin
               root_o <= rf[R_RES][WIDTH/2-1:0];
               rem_o <= rf[R_X];
               out_valid <= 1'b1;
            end
         end
         if (state == S_DONE && out_ready) out_valid <= 1'b0;
      end
   end

endmodule
